// File: rtl/uart_rx.sv
// UART receive stage: 2-flop synchroniser, 16x oversampled start detection,
// LSB-first deserialisation, valid/ready delivery with framing/overrun pulses.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_DIV   = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e                  state_q, state_d;
    logic                    sync1_q, rx_s_q;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [3:0]              samp_q, samp_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    oerr_q, oerr_d;
    logic                    busy_q, busy_d;
    logic                    tick;
    logic                    entry;

    assign tick = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        data_d  = data_q;
        // A transfer clears valid; a new load below overrides it.
        valid_d = valid_q & ~rx_ready;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (tick && samp_q == 4'd7) begin
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && samp_q == 4'd15) begin
                    shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick && samp_q == 4'd15) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            oerr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        entry = (state_d != state_q);

        // Restarting the divider on START entry phase-aligns ticks to the start edge.
        if ((state_q == S_IDLE && state_d == S_START) || tick) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        if (entry) begin
            samp_d = '0;
        end else if (tick) begin
            samp_d = samp_q + 4'd1;
        end else begin
            samp_d = samp_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BAUD_DIV = 4 (64 clk per bit).
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int fe_cyc = 0;
    int ov_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    int busy_cnt = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    logic valid_prev = 1'b0;

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_DIV(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun_err(overrun_err),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (overrun_err) begin
            ov_cnt = ov_cnt + 1;
            ov_cyc = cyc;
        end
        if (frame_err && overrun_err) both_cnt = both_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (rx_valid && !valid_prev) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        if (!rx_valid && valid_prev) fall_cnt = fall_cnt + 1;
        valid_prev = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        fe_cnt   = 0;
        ov_cnt   = 0;
        busy_cnt = 0;
        rise_cnt = 0;
        fall_cnt = 0;
    endtask

    // Drives one 8N1 frame from a negedge; optional one-cycle ready pulse at
    // clk index ready_at, optional reset assertion at clk index abort_at.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int ready_at, input int abort_at);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        fall_cyc = cyc;
        for (int i = 0; i < 640; i++) begin
            if (i == abort_at) begin
                reset = 1'b0;
                return;
            end
            rx = bits[i / 64];
            if (ready_at >= 0) rx_ready = (i == ready_at);
            @(negedge clk);
        end
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_oerr", overrun_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Basic receive
        clear_counts();
        send_frame(8'hA5, 1'b1, -1, -1);
        repeat (10) @(negedge clk);
        check("basic_valid", rx_valid, 1);
        check("basic_data", rx_data, 8'hA5);
        check("basic_latency", rise_cyc - fall_cyc, 611);
        check("basic_ferr", fe_cnt, 0);
        check("basic_busy", busy, 0);

        // Handshake
        accept();
        check("hs_valid", rx_valid, 0);
        repeat (10) @(negedge clk);

        // Glitch rejection: START is entered at +3 and abandoned at tick 8 (+35)
        clear_counts();
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_busy_cycles", busy_cnt, 32);
        check("glitch_busy", busy, 0);
        check("glitch_valid", rise_cnt, 0);
        check("glitch_ferr", fe_cnt, 0);
        check("glitch_oerr", ov_cnt, 0);

        // Framing error followed by a 3-bit break, then a clean frame
        clear_counts();
        send_frame(8'h3C, 1'b0, -1, -1);
        rx = 1'b0;
        repeat (192) @(negedge clk);
        check("brk_busy_held", busy, 1);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        check("brk_ferr_cnt", fe_cnt, 1);
        check("brk_ferr_time", fe_cyc - fall_cyc, 611);
        check("brk_no_valid", rise_cnt, 0);
        check("brk_idle", busy, 0);
        send_frame(8'h55, 1'b1, -1, -1);
        repeat (10) @(negedge clk);
        check("brk_rx55_valid", rx_valid, 1);
        check("brk_rx55_data", rx_data, 8'h55);
        check("brk_ferr_total", fe_cnt, 1);
        check("brk_oerr", ov_cnt, 0);
        accept();

        // Overrun: back-to-back frames with no consumer
        clear_counts();
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        repeat (10) @(negedge clk);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check("ovr_cnt", ov_cnt, 1);
        check("ovr_time", ov_cyc - fall_cyc, 611);
        check("ovr_ferr", fe_cnt, 0);
        accept();
        check("ovr_consumed", rx_valid, 0);
        repeat (10) @(negedge clk);

        // Simultaneous accept in the completion cycle
        clear_counts();
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, 610, -1);
        repeat (10) @(negedge clk);
        check("sim_data", rx_data, 8'h22);
        check("sim_valid", rx_valid, 1);
        check("sim_no_drop", fall_cnt, 0);
        check("sim_oerr", ov_cnt, 0);

        // Reset mid-frame during data bit 3 while 0x22 is still pending
        send_frame(8'hF0, 1'b1, -1, 276);
        #1;
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_oerr", overrun_err, 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        clear_counts();
        send_frame(8'h7E, 1'b1, -1, -1);
        repeat (10) @(negedge clk);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'h7E);
        check("post_rst_ferr", fe_cnt, 0);
        check("err_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive stage for the UART peripheral. It sits between the external `rx` pin and the UART register/bus interface. It synchronises the asynchronous line, finds start bits using 16x oversampling, and deserialises 8N1 frames LSB-first. Each completed byte goes out on a valid/ready handshake to the register block, together with framing-error and overrun indications.

## Interface

Parameters:
- `DATA_WIDTH`, 8: data bits per frame, and width of `rx_data`.
- `BAUD_DIV`, 27: clk cycles per oversample tick (bit period = 16 × `BAUD_DIV` clk). Must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous; idle high.
- `rx_data`  out  `DATA_WIDTH`  received byte; stable while `rx_valid` = 1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts; a transfer occurs in a cycle with `rx_valid` & `rx_ready`.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun_err`  out  1  one-cycle pulse when a completed byte is dropped.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- Synchroniser: two flops on `rx` produce `rx_s`. Both flops reset to 1.
- Tick generator: a counter runs 0..`BAUD_DIV`-1 and pulses `tick` when at `BAUD_DIV`-1.
  - The counter is cleared on entry to START, so ticks are phase-aligned to the start edge.
- Sample counter: 4 bits, counts ticks; cleared on every state entry.
- Bit counter: counts data bits 0..`DATA_WIDTH`-1.
- State machine:
  - IDLE: when `rx_s` = 0, go to START.
  - START: on the 8th tick (mid start bit):
    - if `rx_s` = 1, it was a false start; go to IDLE;
    - otherwise go to DATA.
  - DATA: on every 16th tick, shift `rx_s` in LSB-first. After the `DATA_WIDTH`-th bit, go to STOP.
  - STOP: on the 16th tick, sample the stop bit:
    - if 1, deliver the byte and go to IDLE;
    - if 0, pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait until `rx_s` = 1, then go to IDLE. This prevents a held-low line from re-triggering reception.
- Delivery at a good stop bit:
  - if `rx_valid` = 0, or `rx_ready` = 1 in the same cycle: load `rx_data`, set `rx_valid` = 1, no error;
  - otherwise: keep the old `rx_data`, keep `rx_valid` = 1, pulse `overrun_err`, drop the new byte.
- `rx_valid` clears the cycle after a transfer, unless a new byte is loaded in that same cycle.
- `rx_ready` has no effect while `rx_valid` = 0.
- `frame_err` and `overrun_err` are never asserted together.
- Reset mid-frame aborts reception immediately. Pending `rx_data` and `rx_valid` are lost.

## Timing

- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun_err` = 0, `busy` = 0;
  - state = IDLE, all counters = 0, synchroniser = 1.
- Synchroniser latency: 2 clk from `rx` to `rx_s`.
- Entry into START happens 1 clk after `rx_s` is first seen low.
- Tick timing: the n-th tick after START entry occurs n × `BAUD_DIV` clk after entry.
- Sample points, counted in ticks after START entry:
  - start bit: 8;
  - data bit k: 8 + 16(k+1);
  - stop bit: 8 + 16(`DATA_WIDTH`+1) = 152 for 8 bits.
- Outputs: `rx_valid`, `rx_data`, `frame_err` and `overrun_err` update on the clk edge following the stop-sample tick. All outputs are registered.
- `busy` rises with START entry and falls with the return to IDLE.
- Back-to-back frames: the next start bit can be detected from the first IDLE cycle onward. This tolerates a stop bit shortened by up to half a bit.

## Test plan

All scenarios use `BAUD_DIV` = 4 (bit period 64 clk).

- Basic receive: drive 8N1 frame 0xA5, `rx_ready` = 0.
  - Required: `rx_data` = 0xA5, `rx_valid` = 1 about 152×4+3 clk after the falling edge; `frame_err` = 0.
- Handshake: `rx_ready` = 1 for one cycle.
  - Required: `rx_valid` = 0 on the next cycle.
- Glitch rejection: drive `rx` low for 16 clk, then high.
  - Required: `busy` pulses; `rx_valid`, `frame_err` and `overrun_err` stay 0; FSM back in IDLE by the mid-start check.
- Framing/break: frame 0x3C with a low stop bit, then hold `rx` low for 3 bit times, then send frame 0x55.
  - Required: exactly one `frame_err` pulse and no `rx_valid` for 0x3C; no activity during the break; `rx_data` = 0x55 received cleanly afterwards.
- Overrun: frames 0x11 then 0x22 back-to-back, `rx_ready` = 0.
  - Required: `rx_data` stays 0x11, one `overrun_err` pulse at the 0x22 stop sample.
  - Then raise `rx_ready`: 0x11 is consumed and `rx_valid` drops.
- Simultaneous accept: same as overrun, but `rx_ready` = 1 exactly in the 0x22 completion cycle.
  - Required: `rx_data` = 0x22, `rx_valid` stays 1, no `overrun_err`.
- Reset mid-frame: assert `reset` low during data bit 3 of a frame.
  - Required: all outputs at reset values immediately.
  - After release, frame 0x7E is received correctly.
